// File: rtl/accelerator_content_based_addressing_feeder_pkg.sv
// Shared constants, FSM encoding and write-target codes for the
// content-based addressing feeder.
package accelerator_content_based_addressing_feeder_pkg;

  localparam int DATA_SIZE    = 64;
  localparam int CONTROL_SIZE = 64;
  localparam int ADDR_I       = 4;
  localparam int ADDR_J       = 4;
  localparam int ADDR_M       = ADDR_I + ADDR_J;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] WSEL_K      = 3'd0;
  localparam logic [2:0] WSEL_M      = 3'd1;
  localparam logic [2:0] WSEL_BETA   = 3'd2;
  localparam logic [2:0] WSEL_SIZE_I = 3'd3;
  localparam logic [2:0] WSEL_SIZE_J = 3'd4;

  localparam logic [DATA_SIZE-1:0] ZERO = {DATA_SIZE{1'b0}};
  localparam logic [DATA_SIZE-1:0] ONE  = {{(DATA_SIZE-1){1'b0}}, 1'b1};

  // A size is usable when it lies in 1..2^addr_bits.
  function automatic logic size_ok(input logic [DATA_SIZE-1:0] size, input int addr_bits);
    return (size != ZERO) && (size <= (ONE << addr_bits));
  endfunction

endpackage

// File: rtl/accelerator_content_based_addressing_feeder_if.sv
// Host-bus plus accelerator-side handshake bundle; the feeder is the slave,
// the host/accelerator environment is the master.
interface accelerator_content_based_addressing_feeder_if;
  import accelerator_content_based_addressing_feeder_pkg::*;

  logic                 HOST_START;
  logic                 HOST_READY;
  logic                 ERROR;
  logic                 WRITE_ENABLE;
  logic [2:0]           WRITE_SELECT;
  logic [ADDR_M-1:0]    WRITE_ADDR;
  logic [DATA_SIZE-1:0] WRITE_DATA;
  logic [ADDR_I-1:0]    READ_ADDR;
  logic [DATA_SIZE-1:0] READ_DATA;
  logic                 START;
  logic                 READY;
  logic                 K_OUT_ENABLE;
  logic                 K_IN_ENABLE;
  logic                 M_OUT_I_ENABLE;
  logic                 M_OUT_J_ENABLE;
  logic                 M_IN_I_ENABLE;
  logic                 M_IN_J_ENABLE;
  logic                 C_OUT_ENABLE;
  logic [DATA_SIZE-1:0] C_OUT;
  logic [DATA_SIZE-1:0] SIZE_I_IN;
  logic [DATA_SIZE-1:0] SIZE_J_IN;
  logic [DATA_SIZE-1:0] BETA_IN;
  logic [DATA_SIZE-1:0] K_IN;
  logic [DATA_SIZE-1:0] M_IN;

  modport slave (
    input  HOST_START, WRITE_ENABLE, WRITE_SELECT, WRITE_ADDR, WRITE_DATA, READ_ADDR,
           READY, K_OUT_ENABLE, M_OUT_I_ENABLE, M_OUT_J_ENABLE, C_OUT_ENABLE, C_OUT,
    output HOST_READY, ERROR, READ_DATA, START, K_IN_ENABLE, M_IN_I_ENABLE, M_IN_J_ENABLE,
           SIZE_I_IN, SIZE_J_IN, BETA_IN, K_IN, M_IN
  );

  modport master (
    output HOST_START, WRITE_ENABLE, WRITE_SELECT, WRITE_ADDR, WRITE_DATA, READ_ADDR,
           READY, K_OUT_ENABLE, M_OUT_I_ENABLE, M_OUT_J_ENABLE, C_OUT_ENABLE, C_OUT,
    input  HOST_READY, ERROR, READ_DATA, START, K_IN_ENABLE, M_IN_I_ENABLE, M_IN_J_ENABLE,
           SIZE_I_IN, SIZE_J_IN, BETA_IN, K_IN, M_IN
  );

endinterface

// File: rtl/accelerator_feeder_ram.sv
// Synchronous-write array with a registered, enable-gated read port; the read
// register holds its value while i_rd_en is low and clears on reset.
module accelerator_feeder_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= {WIDTH{1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/accelerator_content_based_addressing_feeder.sv
// Feeder top: buffers K/M/BETA from the host, launches the accelerator,
// streams K and M on request and captures the returned C vector.
module accelerator_content_based_addressing_feeder
  import accelerator_content_based_addressing_feeder_pkg::*;
(
  input logic CLK,
  input logic RST,
  accelerator_content_based_addressing_feeder_if.slave bus
);

  state_t               r_state;
  logic [DATA_SIZE-1:0] r_size_i, r_size_j, r_beta;
  logic [ADDR_J-1:0]    r_k, r_j;
  logic [ADDR_I-1:0]    r_i, r_c;
  logic                 r_c_full;
  logic                 r_start, r_host_ready, r_error;
  logic                 r_k_en, r_mi_en, r_mj_en;

  logic                 w_idle, w_launch, w_stream, w_wr_host, w_start_ok;
  logic [ADDR_J-1:0]    w_szj_m1;
  logic [ADDR_I-1:0]    w_szi_m1;
  logic                 w_k_last, w_i_last, w_j_last;
  logic                 w_k_req, w_mi_req, w_mj_req, w_c_req;
  logic                 w_k_go, w_mi_go, w_mj_go, w_c_go, w_err_set;
  logic [ADDR_J-1:0]    w_k_rd_addr;
  logic [ADDR_M-1:0]    w_m_rd_addr;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_launch   = (r_state == ST_LAUNCH);
  assign w_stream   = (r_state == ST_STREAM);
  assign w_wr_host  = bus.WRITE_ENABLE && w_idle;
  assign w_start_ok = size_ok(r_size_i, ADDR_I) && size_ok(r_size_j, ADDR_J);

  // Sizes are at most 2^ADDR, so size-1 always fits in the pointer width.
  assign w_szj_m1 = r_size_j[ADDR_J-1:0] - ADDR_J'(1'b1);
  assign w_szi_m1 = r_size_i[ADDR_I-1:0] - ADDR_I'(1'b1);
  assign w_k_last = (r_k == w_szj_m1);
  assign w_j_last = (r_j == w_szj_m1);
  assign w_i_last = (r_i == w_szi_m1);

  assign w_k_req  = w_stream && bus.K_OUT_ENABLE;
  assign w_mi_req = w_stream && bus.M_OUT_I_ENABLE;
  assign w_mj_req = w_stream && bus.M_OUT_J_ENABLE && !bus.M_OUT_I_ENABLE;
  assign w_c_req  = w_stream && bus.C_OUT_ENABLE;
  assign w_k_go   = w_k_req && !w_k_last;
  assign w_mi_go  = w_mi_req && !w_i_last;
  assign w_mj_go  = w_mj_req && !w_j_last;
  assign w_c_go   = w_c_req && !r_c_full;
  assign w_err_set = (w_k_req && w_k_last) || (w_mi_req && w_i_last) ||
                     (w_mj_req && w_j_last) || (w_c_req && r_c_full);

  always_comb begin
    w_k_rd_addr = r_k + ADDR_J'(1'b1);
    w_m_rd_addr = {r_i, r_j + ADDR_J'(1'b1)};
    if (w_launch) begin
      w_k_rd_addr = {ADDR_J{1'b0}};
      w_m_rd_addr = {ADDR_M{1'b0}};
    end else if (w_mi_go) begin
      w_m_rd_addr = {r_i + ADDR_I'(1'b1), {ADDR_J{1'b0}}};
    end else begin
      w_m_rd_addr = {r_i, r_j + ADDR_J'(1'b1)};
    end
  end

  accelerator_feeder_ram #(.DEPTH(2 ** ADDR_J), .WIDTH(DATA_SIZE)) u_k_ram (
    .i_clk(CLK), .i_rst(RST),
    .i_wr_en(w_wr_host && (bus.WRITE_SELECT == WSEL_K)),
    .i_wr_addr(bus.WRITE_ADDR[ADDR_J-1:0]), .i_wr_data(bus.WRITE_DATA),
    .i_rd_en(w_launch || w_k_go), .i_rd_addr(w_k_rd_addr), .o_rd_data(bus.K_IN)
  );

  accelerator_feeder_ram #(.DEPTH(2 ** ADDR_M), .WIDTH(DATA_SIZE)) u_m_ram (
    .i_clk(CLK), .i_rst(RST),
    .i_wr_en(w_wr_host && (bus.WRITE_SELECT == WSEL_M)),
    .i_wr_addr(bus.WRITE_ADDR), .i_wr_data(bus.WRITE_DATA),
    .i_rd_en(w_launch || w_mi_go || w_mj_go), .i_rd_addr(w_m_rd_addr), .o_rd_data(bus.M_IN)
  );

  accelerator_feeder_ram #(.DEPTH(2 ** ADDR_I), .WIDTH(DATA_SIZE)) u_c_ram (
    .i_clk(CLK), .i_rst(RST),
    .i_wr_en(w_c_go), .i_wr_addr(r_c), .i_wr_data(bus.C_OUT),
    .i_rd_en(1'b1), .i_rd_addr(bus.READ_ADDR), .o_rd_data(bus.READ_DATA)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_size_i     <= ZERO;
      r_size_j     <= ZERO;
      r_beta       <= ZERO;
      r_k          <= {ADDR_J{1'b0}};
      r_j          <= {ADDR_J{1'b0}};
      r_i          <= {ADDR_I{1'b0}};
      r_c          <= {ADDR_I{1'b0}};
      r_c_full     <= 1'b0;
      r_start      <= 1'b0;
      r_host_ready <= 1'b0;
      r_error      <= 1'b0;
      r_k_en       <= 1'b0;
      r_mi_en      <= 1'b0;
      r_mj_en      <= 1'b0;
    end else begin
      r_start      <= 1'b0;
      r_host_ready <= 1'b0;
      r_k_en       <= 1'b0;
      r_mi_en      <= 1'b0;
      r_mj_en      <= 1'b0;
      if (w_wr_host) begin
        case (bus.WRITE_SELECT)
          WSEL_BETA:   r_beta   <= bus.WRITE_DATA;
          WSEL_SIZE_I: r_size_i <= bus.WRITE_DATA;
          WSEL_SIZE_J: r_size_j <= bus.WRITE_DATA;
          default:     r_beta   <= r_beta;
        endcase
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.HOST_START && w_start_ok) begin
            r_error  <= 1'b0;
            r_k      <= {ADDR_J{1'b0}};
            r_j      <= {ADDR_J{1'b0}};
            r_i      <= {ADDR_I{1'b0}};
            r_c      <= {ADDR_I{1'b0}};
            r_c_full <= 1'b0;
            r_start  <= 1'b1;
            r_state  <= ST_LAUNCH;
          end else if (bus.HOST_START) begin
            r_error <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          r_k_en  <= 1'b1;
          r_mi_en <= 1'b1;
          r_mj_en <= 1'b1;
          r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_k_go) begin
            r_k    <= r_k + ADDR_J'(1'b1);
            r_k_en <= 1'b1;
          end
          if (w_mi_go) begin
            r_i     <= r_i + ADDR_I'(1'b1);
            r_j     <= {ADDR_J{1'b0}};
            r_mi_en <= 1'b1;
            r_mj_en <= 1'b1;
          end else if (w_mj_go) begin
            r_j     <= r_j + ADDR_J'(1'b1);
            r_mj_en <= 1'b1;
          end
          // c wraps at 2^ADDR_I, so fullness is tracked separately.
          if (w_c_go) begin
            r_c <= r_c + ADDR_I'(1'b1);
            if (r_c == w_szi_m1) begin
              r_c_full <= 1'b1;
            end
          end
          if (w_err_set) begin
            r_error <= 1'b1;
          end
          if (bus.READY) begin
            r_host_ready <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.START         = r_start;
  assign bus.HOST_READY    = r_host_ready;
  assign bus.ERROR         = r_error;
  assign bus.K_IN_ENABLE   = r_k_en;
  assign bus.M_IN_I_ENABLE = r_mi_en;
  assign bus.M_IN_J_ENABLE = r_mj_en;
  assign bus.SIZE_I_IN     = r_size_i;
  assign bus.SIZE_J_IN     = r_size_j;
  assign bus.BETA_IN       = r_beta;

endmodule

// File: tb/tb_accelerator_content_based_addressing_feeder.sv
// Directed, table-driven bench for the content-based addressing feeder.
module tb_accelerator_content_based_addressing_feeder;
  import accelerator_content_based_addressing_feeder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  accelerator_content_based_addressing_feeder_if bus_if ();

  accelerator_content_based_addressing_feeder dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        k_req, mi_req, mj_req, c_en, rdy;
    logic [63:0] c_data;
    logic        e_ken, e_mien, e_mjen, e_hr;
    logic [63:0] e_k, e_m;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [2:0] sel, input logic [7:0] addr, input logic [63:0] data);
    bus_if.WRITE_ENABLE = 1'b1;
    bus_if.WRITE_SELECT = sel;
    bus_if.WRITE_ADDR   = addr;
    bus_if.WRITE_DATA   = data;
    step();
    bus_if.WRITE_ENABLE = 1'b0;
  endtask

  task automatic launch(input logic [63:0] k0, input logic [63:0] m0);
    bus_if.HOST_START = 1'b1;
    step();
    bus_if.HOST_START = 1'b0;
    chk("start_pulse", bus_if.START, 1);
    chk("error_cleared", bus_if.ERROR, 0);
    step();
    chk("start_low", bus_if.START, 0);
    chk("first_k_en", bus_if.K_IN_ENABLE, 1);
    chk("first_k", bus_if.K_IN, k0);
    chk("first_mi_en", bus_if.M_IN_I_ENABLE, 1);
    chk("first_mj_en", bus_if.M_IN_J_ENABLE, 1);
    chk("first_m", bus_if.M_IN, m0);
  endtask

  task automatic clear_reqs();
    bus_if.K_OUT_ENABLE   = 1'b0;
    bus_if.M_OUT_I_ENABLE = 1'b0;
    bus_if.M_OUT_J_ENABLE = 1'b0;
    bus_if.C_OUT_ENABLE   = 1'b0;
    bus_if.READY          = 1'b0;
  endtask

  initial begin
    bus_if.HOST_START   = 1'b0;
    bus_if.WRITE_ENABLE = 1'b0;
    bus_if.WRITE_SELECT = 3'd0;
    bus_if.WRITE_ADDR   = 8'd0;
    bus_if.WRITE_DATA   = 64'd0;
    bus_if.READ_ADDR    = 4'd0;
    bus_if.C_OUT        = 64'd0;
    clear_reqs();

    // k, mi, mj, c, rdy, c_data | ken, mien, mjen, hr, K, M
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,  1'b1, 1'b0, 1'b0, 1'b0, 64'd2, 64'd4};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,  1'b1, 1'b0, 1'b1, 1'b0, 64'd3, 64'd5};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b1, 1'b0, 64'd3, 64'd6};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b1, 1'b1, 1'b0, 64'd3, 64'd7};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b1, 1'b0, 64'd3, 64'd8};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b1, 1'b0, 64'd3, 64'd9};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd10, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3, 64'd9};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd11, 1'b0, 1'b0, 1'b0, 1'b1, 64'd3, 64'd9};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'd3, 64'd9};

    // Reset state
    #2 rst = 1'b1;
    #10;
    chk("rst_start", bus_if.START, 0);
    chk("rst_host_ready", bus_if.HOST_READY, 0);
    chk("rst_error", bus_if.ERROR, 0);
    chk("rst_k_en", bus_if.K_IN_ENABLE, 0);
    chk("rst_mi_en", bus_if.M_IN_I_ENABLE, 0);
    chk("rst_mj_en", bus_if.M_IN_J_ENABLE, 0);
    chk("rst_k_in", bus_if.K_IN, 0);
    chk("rst_m_in", bus_if.M_IN, 0);
    chk("rst_size_i", bus_if.SIZE_I_IN, 0);
    chk("rst_size_j", bus_if.SIZE_J_IN, 0);
    chk("rst_beta", bus_if.BETA_IN, 0);
    chk("rst_read_data", bus_if.READ_DATA, 0);
    #10 rst = 1'b0;

    // Full run: SIZE_I=2, SIZE_J=3
    for (int k = 0; k < 3; k++) host_wr(WSEL_K, 8'(k), 64'(k + 1));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        host_wr(WSEL_M, {4'(r), 4'(c)}, 64'(4 + 3 * r + c));
    host_wr(WSEL_SIZE_I, 8'd0, 64'd2);
    host_wr(WSEL_SIZE_J, 8'd0, 64'd3);
    host_wr(WSEL_BETA, 8'd0, 64'h55);
    chk("size_i_in", bus_if.SIZE_I_IN, 64'd2);
    chk("size_j_in", bus_if.SIZE_J_IN, 64'd3);
    chk("beta_in", bus_if.BETA_IN, 64'h55);
    launch(64'd1, 64'd4);
    for (int n = 0; n < 9; n++) begin
      bus_if.K_OUT_ENABLE   = tbl[n].k_req;
      bus_if.M_OUT_I_ENABLE = tbl[n].mi_req;
      bus_if.M_OUT_J_ENABLE = tbl[n].mj_req;
      bus_if.C_OUT_ENABLE   = tbl[n].c_en;
      bus_if.C_OUT          = tbl[n].c_data;
      bus_if.READY          = tbl[n].rdy;
      step();
      chk($sformatf("row%0d_k_en", n), bus_if.K_IN_ENABLE, tbl[n].e_ken);
      chk($sformatf("row%0d_k_in", n), bus_if.K_IN, tbl[n].e_k);
      chk($sformatf("row%0d_mi_en", n), bus_if.M_IN_I_ENABLE, tbl[n].e_mien);
      chk($sformatf("row%0d_mj_en", n), bus_if.M_IN_J_ENABLE, tbl[n].e_mjen);
      chk($sformatf("row%0d_m_in", n), bus_if.M_IN, tbl[n].e_m);
      chk($sformatf("row%0d_host_ready", n), bus_if.HOST_READY, tbl[n].e_hr);
      chk($sformatf("row%0d_error", n), bus_if.ERROR, 0);
    end
    clear_reqs();
    bus_if.READ_ADDR = 4'd0;
    step();
    chk("read_c0", bus_if.READ_DATA, 64'd10);
    bus_if.READ_ADDR = 4'd1;
    step();
    chk("read_c1", bus_if.READ_DATA, 64'd11);

    // Simultaneous K, I and J requests
    launch(64'd1, 64'd4);
    bus_if.K_OUT_ENABLE   = 1'b1;
    bus_if.M_OUT_I_ENABLE = 1'b1;
    bus_if.M_OUT_J_ENABLE = 1'b1;
    step();
    clear_reqs();
    chk("simul_k_en", bus_if.K_IN_ENABLE, 1);
    chk("simul_k", bus_if.K_IN, 64'd2);
    chk("simul_mi_en", bus_if.M_IN_I_ENABLE, 1);
    chk("simul_mj_en", bus_if.M_IN_J_ENABLE, 1);
    chk("simul_m", bus_if.M_IN, 64'd7);
    chk("simul_error", bus_if.ERROR, 0);
    bus_if.READY = 1'b1;
    step();
    bus_if.READY = 1'b0;
    chk("simul_host_ready", bus_if.HOST_READY, 1);
    step();
    chk("simul_host_ready_low", bus_if.HOST_READY, 0);

    // Size error: SIZE_J=0
    host_wr(WSEL_SIZE_J, 8'd0, 64'd0);
    bus_if.HOST_START = 1'b1;
    step();
    bus_if.HOST_START = 1'b0;
    chk("szerr_start", bus_if.START, 0);
    chk("szerr_error", bus_if.ERROR, 1);
    step();
    chk("szerr_start2", bus_if.START, 0);
    chk("szerr_k_en", bus_if.K_IN_ENABLE, 0);
    host_wr(WSEL_BETA, 8'd0, 64'h77);
    chk("szerr_still_idle", bus_if.BETA_IN, 64'h77);

    // Over-request with SIZE_J=2, plus write lockout during STREAM
    host_wr(WSEL_SIZE_J, 8'd0, 64'd2);
    launch(64'd1, 64'd4);
    bus_if.K_OUT_ENABLE = 1'b1;
    step();
    chk("over_k1_en", bus_if.K_IN_ENABLE, 1);
    chk("over_k1", bus_if.K_IN, 64'd2);
    chk("over_err_early", bus_if.ERROR, 0);
    step();
    bus_if.K_OUT_ENABLE = 1'b0;
    chk("over_k2_en", bus_if.K_IN_ENABLE, 0);
    chk("over_k2_hold", bus_if.K_IN, 64'd2);
    chk("over_error", bus_if.ERROR, 1);
    host_wr(WSEL_BETA, 8'd0, 64'hAA);
    chk("lockout_beta", bus_if.BETA_IN, 64'h77);
    bus_if.READY = 1'b1;
    step();
    bus_if.READY = 1'b0;
    chk("over_host_ready", bus_if.HOST_READY, 1);
    chk("over_error_sticky", bus_if.ERROR, 1);
    step();
    chk("over_host_ready_low", bus_if.HOST_READY, 0);

    // Reset mid-run, then a clean rerun with the sizes rewritten
    host_wr(WSEL_SIZE_J, 8'd0, 64'd3);
    launch(64'd1, 64'd4);
    bus_if.K_OUT_ENABLE = 1'b1;
    step();
    bus_if.K_OUT_ENABLE = 1'b0;
    chk("midrst_pre_k", bus_if.K_IN, 64'd2);
    rst = 1'b1;
    #2;
    chk("midrst_k_in", bus_if.K_IN, 0);
    chk("midrst_m_in", bus_if.M_IN, 0);
    chk("midrst_size_i", bus_if.SIZE_I_IN, 0);
    chk("midrst_beta", bus_if.BETA_IN, 0);
    step();
    rst = 1'b0;
    step();
    chk("midrst_no_host_ready", bus_if.HOST_READY, 0);
    chk("midrst_no_start", bus_if.START, 0);
    host_wr(WSEL_SIZE_I, 8'd0, 64'd2);
    host_wr(WSEL_SIZE_J, 8'd0, 64'd3);
    launch(64'd1, 64'd4);
    bus_if.M_OUT_I_ENABLE = 1'b1;
    step();
    bus_if.M_OUT_I_ENABLE = 1'b0;
    chk("rerun_mi_en", bus_if.M_IN_I_ENABLE, 1);
    chk("rerun_m", bus_if.M_IN, 64'd7);
    bus_if.C_OUT_ENABLE = 1'b1;
    bus_if.C_OUT        = 64'h21;
    bus_if.READY        = 1'b1;
    step();
    clear_reqs();
    chk("rerun_host_ready", bus_if.HOST_READY, 1);
    bus_if.READ_ADDR = 4'd0;
    step();
    chk("rerun_read_c0", bus_if.READ_DATA, 64'h21);
    chk("rerun_error", bus_if.ERROR, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
